// File: rtl/gauss_pkg.sv
// Shared constants for the streaming 3x3 Gaussian filter.
package gauss_pkg;

   // Kernel weights sum to 16: normalise with a 4-bit shift, half-LSB for rounding.
   localparam int unsigned GAUSS_SHIFT = 4;
   localparam int unsigned GAUSS_HALF  = 8;

   // Run-time mode encoding.
   localparam logic MODE_GAUSS  = 1'b0;
   localparam logic MODE_BYPASS = 1'b1;

   // Width growth over DATA_W: column sum (weights 1+2+1) and full window sum (x16).
   localparam int unsigned CS_OFS  = 2;
   localparam int unsigned SUM_OFS = 4;

   // Window fill levels.
   localparam logic [1:0] FILL_EMPTY = 2'd0;
   localparam logic [1:0] FILL_ONE   = 2'd1;
   localparam logic [1:0] FILL_FULL  = 2'd2;

endpackage : gauss_pkg

// File: rtl/gauss_col_sum.sv
// Vertical [1 2 1] weighting of one incoming 3-pixel column.
module gauss_col_sum
   import gauss_pkg::*;
#(
   parameter int unsigned DATA_W = 8
) (
   input  logic [DATA_W-1:0]        top,
   input  logic [DATA_W-1:0]        mid,
   input  logic [DATA_W-1:0]        bot,
   output logic [DATA_W+CS_OFS-1:0] col_sum
);

   localparam int unsigned CS_W = DATA_W + CS_OFS;

   // top + 2*mid + bot, widened first so nothing overflows.
   always_comb begin
      col_sum = CS_W'(top) + (CS_W'(mid) << 1) + CS_W'(bot);
   end

endmodule : gauss_col_sum

// File: rtl/gauss3x3_stream.sv
// Streaming 3x3 Gaussian filter: sliding 3-column window, one output register
// with pass-through ready, optional bypass of the centre pixel.
module gauss3x3_stream
   import gauss_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ROUND  = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_sol,
   input  logic [DATA_W-1:0] in_top,
   input  logic [DATA_W-1:0] in_mid,
   input  logic [DATA_W-1:0] in_bot,
   input  logic              mode,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data
);

   localparam int unsigned CS_W    = DATA_W + CS_OFS;
   localparam int unsigned SUM_W   = DATA_W + SUM_OFS;
   localparam int unsigned RND_ADD = (ROUND != 0) ? GAUSS_HALF : 0;

   logic [CS_W-1:0]   cs_new;
   logic [CS_W-1:0]   cs_l;
   logic [CS_W-1:0]   cs_c;
   logic [DATA_W-1:0] mid_c;
   logic [1:0]        fill;
   logic              accept;
   logic              produce;
   logic [SUM_W-1:0]  sum;
   logic [SUM_W-1:0]  sum_rnd;
   logic [DATA_W-1:0] gauss_pix;
   logic [DATA_W-1:0] next_pix;

   gauss_col_sum #(
      .DATA_W (DATA_W)
   ) u_col_sum (
      .top     (in_top),
      .mid     (in_mid),
      .bot     (in_bot),
      .col_sum (cs_new)
   );

   // Ready whenever the output register is empty or being drained this cycle.
   assign in_ready = !out_valid || out_ready;

   // Handshake qualification and horizontal [1 2 1] weighting of the window.
   always_comb begin
      accept    = in_valid && in_ready;
      produce   = accept && !in_sol && (fill == FILL_FULL);
      sum       = SUM_W'(cs_l) + (SUM_W'(cs_c) << 1) + SUM_W'(cs_new);
      sum_rnd   = sum + SUM_W'(RND_ADD);
      gauss_pix = DATA_W'(sum_rnd >> GAUSS_SHIFT);
      next_pix  = (mode == MODE_BYPASS) ? mid_c : gauss_pix;
   end

   // Window registers: restart on start of line, otherwise shift in the new column.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cs_l  <= '0;
         cs_c  <= '0;
         mid_c <= '0;
         fill  <= FILL_EMPTY;
      end else if (accept) begin
         cs_c  <= cs_new;
         mid_c <= in_mid;
         if (in_sol) begin
            cs_l <= '0;
            fill <= FILL_ONE;
         end else begin
            cs_l <= cs_c;
            fill <= (fill == FILL_FULL) ? FILL_FULL : fill + 2'd1;
         end
      end
   end

   // Output register: load on a producing accept, clear when drained without reload.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (produce) begin
         out_valid <= 1'b1;
         out_data  <= next_pix;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule : gauss3x3_stream
